// File: rtl/key_event_unit.sv
// Key event controller: synchronizes and debounces eight active-low keys,
// latches press events into W1C flags and raises a maskable level interrupt.
// Register map (Addr): 0 STATE (ro), 1 EVENT (w1c), 2 CTRL {EN, mask}, 3 DEBOUNCE.
module key_event_unit #(
  parameter logic [19:0] DEB_INIT = 20'd50000,
  parameter int unsigned STABLE   = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  input  logic [7:0]  KIn,
  output logic        IRQ
);

  localparam logic [2:0]  STABLE_CNT = 3'(STABLE);
  // The prescaler runs as a down-counter; its reset load is the terminal
  // count of the reset DEBOUNCE value, which matches "count position 0".
  localparam logic [19:0] TERM_INIT  = (DEB_INIT == 20'd0) ? 20'd0 : DEB_INIT - 20'd1;

  logic [7:0]  sync_meta;
  logic [7:0]  key_sync;
  logic [7:0]  level;
  logic [7:0]  level_nxt;
  logic [2:0]  stab_cnt     [8];
  logic [2:0]  stab_cnt_nxt [8];
  logic [7:0]  press;
  logic [7:0]  evt_flags;
  logic [7:0]  mask;
  logic        en;
  logic [19:0] debounce;
  logic [19:0] deb_wr_val;
  logic [19:0] presc;
  logic [19:0] presc_load;
  logic        tick;
  logic        wr_event;
  logic        wr_ctrl;
  logic        wr_deb;
  logic [7:0]  w1c;
  logic        unused_din;

  // Terminal count for a period P = max(p, 1).
  function automatic logic [19:0] term_of(input logic [19:0] p);
    return (p == 20'd0) ? 20'd0 : p - 20'd1;
  endfunction

  assign wr_event   = WE && (Addr == 2'd1);
  assign wr_ctrl    = WE && (Addr == 2'd2);
  assign wr_deb     = WE && (Addr == 2'd3);
  assign w1c        = (wr_event && BE[0]) ? DIn[7:0] : 8'h00;
  assign deb_wr_val = {BE[2] ? DIn[19:16] : debounce[19:16],
                       BE[1] ? DIn[15:8]  : debounce[15:8],
                       BE[0] ? DIn[7:0]   : debounce[7:0]};
  assign unused_din = ^{DIn[31:20], BE[3]};

  assign tick       = (presc == 20'd0);
  assign presc_load = wr_deb ? term_of(deb_wr_val) : term_of(debounce);

  // Two-flop synchronizer on the inverted (active-high pressed) keys.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_meta <= 8'h00;
      key_sync  <= 8'h00;
    end else begin
      sync_meta <= ~KIn;
      key_sync  <= sync_meta;
    end
  end

  // Sample-tick prescaler; any DEBOUNCE write restarts the period.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      presc <= TERM_INIT;
    else if (wr_deb || tick)
      presc <= presc_load;
    else
      presc <= presc - 20'd1;
  end

  // Per-key stability filter: flip the level after STABLE disagreeing ticks.
  always_comb begin
    level_nxt = level;
    press     = 8'h00;
    for (int i = 0; i < 8; i++) begin
      stab_cnt_nxt[i] = stab_cnt[i];
      if (tick) begin
        if (key_sync[i] == level[i]) begin
          stab_cnt_nxt[i] = 3'd0;
        end else if (stab_cnt[i] + 3'd1 == STABLE_CNT) begin
          stab_cnt_nxt[i] = 3'd0;
          level_nxt[i]    = key_sync[i];
          press[i]        = key_sync[i];
        end else begin
          stab_cnt_nxt[i] = stab_cnt[i] + 3'd1;
        end
      end
    end
  end

  // Debounced levels and their stability counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      level <= 8'h00;
      for (int i = 0; i < 8; i++) stab_cnt[i] <= 3'd0;
    end else begin
      level <= level_nxt;
      for (int i = 0; i < 8; i++) stab_cnt[i] <= stab_cnt_nxt[i];
    end
  end

  // Sticky press flags; a new press beats a same-cycle W1C.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      evt_flags <= 8'h00;
    else
      evt_flags <= (evt_flags & ~w1c) | (press & {8{en}});
  end

  // CTRL and DEBOUNCE registers with byte-lane write enables.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mask     <= 8'h00;
      en       <= 1'b0;
      debounce <= DEB_INIT;
    end else begin
      if (wr_ctrl && BE[0]) mask <= DIn[7:0];
      if (wr_ctrl && BE[1]) en   <= DIn[8];
      if (wr_deb)           debounce <= deb_wr_val;
    end
  end

  assign IRQ = en & (|(evt_flags & mask));

  // Read mux, unused bits zero.
  always_comb begin
    DOut = 32'h0;
    case (Addr)
      2'd0:    DOut = {24'h0, level};
      2'd1:    DOut = {24'h0, evt_flags};
      2'd2:    DOut = {23'h0, en, mask};
      default: DOut = {12'h0, debounce};
    endcase
  end

endmodule

// File: tb/tb_key_event_unit.sv
// Bench for key_event_unit: a cycle model of the register-level behaviour
// checked every cycle, plus directed scenarios with literal expectations.
module tb_key_event_unit;

  localparam int M_STABLE = 3;

  logic        Clk;
  logic        Reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [3:0]  BE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic [7:0]  KIn;
  logic        IRQ;

  int n_chk  = 0;
  int n_fail = 0;

  key_event_unit dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Addr (Addr),
    .WE   (WE),
    .BE   (BE),
    .DIn  (DIn),
    .DOut (DOut),
    .KIn  (KIn),
    .IRQ  (IRQ)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Model state: key history, tick phase, streak lengths, registers.
  logic [7:0]  m_s1, m_s2, m_level, m_event, m_mask;
  logic        m_en;
  logic [19:0] m_deb;
  int          m_ph;
  int          m_run [8];

  logic [7:0]  n_level, n_event, n_mask, m_pressed, m_clr;
  logic        n_en, m_tick;
  logic [19:0] n_deb;
  int          n_ph, m_period;
  int          n_run [8];

  // Next model state from the current state and bus/key inputs.
  always_comb begin
    n_level   = m_level;
    n_mask    = m_mask;
    n_en      = m_en;
    n_deb     = m_deb;
    m_pressed = 8'h00;
    m_clr     = 8'h00;
    m_period  = (m_deb == 20'd0) ? 1 : int'(m_deb);
    m_tick    = (m_ph == m_period - 1);
    n_ph      = m_tick ? 0 : m_ph + 1;
    for (int i = 0; i < 8; i++) begin
      n_run[i] = m_run[i];
      if (m_tick) begin
        if (m_s2[i] == m_level[i]) begin
          n_run[i] = 0;
        end else if (m_run[i] + 1 >= M_STABLE) begin
          n_run[i]     = 0;
          n_level[i]   = m_s2[i];
          m_pressed[i] = m_s2[i];
        end else begin
          n_run[i] = m_run[i] + 1;
        end
      end
    end
    if (WE) begin
      case (Addr)
        2'd1: if (BE[0]) m_clr = DIn[7:0];
        2'd2: begin
          if (BE[0]) n_mask = DIn[7:0];
          if (BE[1]) n_en   = DIn[8];
        end
        2'd3: begin
          if (BE[0]) n_deb[7:0]   = DIn[7:0];
          if (BE[1]) n_deb[15:8]  = DIn[15:8];
          if (BE[2]) n_deb[19:16] = DIn[19:16];
          n_ph = 0;
        end
        default: ;
      endcase
    end
    n_event = (m_event & ~m_clr) | (m_en ? m_pressed : 8'h00);
  end

  // Model registers.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_s1 <= 8'h00; m_s2 <= 8'h00; m_level <= 8'h00; m_event <= 8'h00;
      m_mask <= 8'h00; m_en <= 1'b0; m_deb <= 20'd50000; m_ph <= 0;
      for (int i = 0; i < 8; i++) m_run[i] <= 0;
    end else begin
      m_s1 <= ~KIn; m_s2 <= m_s1; m_level <= n_level; m_event <= n_event;
      m_mask <= n_mask; m_en <= n_en; m_deb <= n_deb; m_ph <= n_ph;
      for (int i = 0; i < 8; i++) m_run[i] <= n_run[i];
    end
  end

  function automatic logic [31:0] exp_dout(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_level};
      2'd1:    return {24'h0, m_event};
      2'd2:    return {23'h0, m_en, m_mask};
      default: return {12'h0, m_deb};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    chk("model_dout", DOut, exp_dout(Addr));
    chk("model_irq", {31'h0, IRQ}, {31'h0, m_en & (|(m_event & m_mask))});
  end

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    @(posedge Clk); #1;
    Addr = a; WE = 1'b1; BE = be; DIn = d;
    @(posedge Clk); #1;
    WE = 1'b0; BE = 4'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    Reset = 1'b1; Addr = 2'd0; WE = 1'b0; BE = 4'h0; DIn = 32'h0; KIn = 8'hFF;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    Addr = 2'd3;
    #1 chk("deb_reset_val", DOut, 32'd50000);

    // Reset asserted mid-event.
    wr(2'd3, 4'b0111, 32'h0);
    wr(2'd2, 4'b0011, 32'h1FF);
    KIn[7] = 1'b0;
    repeat (10) @(posedge Clk);
    #1 Addr = 2'd1;
    #1 chk("evt_pre_reset", DOut, 32'h80);
    chk("irq_pre_reset", {31'h0, IRQ}, 32'h1);
    Addr = 2'd3;
    #1 Reset = 1'b1;
    #1 chk("reset_deb", DOut, 32'd50000);
    chk("reset_irq", {31'h0, IRQ}, 32'h0);
    @(negedge Clk); #1;
    KIn = 8'hFF;
    Addr = 2'd0; #1 chk("reset_state", DOut, 32'h0);
    Addr = 2'd1; #1 chk("reset_event", DOut, 32'h0);
    Addr = 2'd2; #1 chk("reset_ctrl", DOut, 32'h0);
    @(posedge Clk); #1 Reset = 1'b0;

    // Clean press of key 2.
    wr(2'd3, 4'b0111, 32'd4);
    wr(2'd2, 4'b0011, 32'h1FF);
    Addr = 2'd0;
    KIn[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (!seen) begin
        @(posedge Clk); #1;
        if (DOut[2]) seen = 1'b1;
      end
    end
    chk("press_within_14", {31'h0, seen}, 32'h1);
    chk("press_state", DOut, 32'h04);
    Addr = 2'd1;
    #1 chk("press_event", DOut, 32'h04);
    chk("press_irq", {31'h0, IRQ}, 32'h1);
    wr(2'd1, 4'b0001, 32'h04);
    #1 chk("w1c_event", DOut, 32'h0);
    chk("w1c_irq", {31'h0, IRQ}, 32'h0);

    // Release, then bounce rejection on key 0.
    KIn = 8'hFF;
    repeat (20) @(posedge Clk);
    #1;
    for (int r = 0; r < 5; r++) begin
      KIn[0] = 1'b0;
      repeat (6) begin @(posedge Clk); #1 chk("bounce_irq", {31'h0, IRQ}, 32'h0); end
      KIn[0] = 1'b1;
      repeat (6) begin @(posedge Clk); #1 chk("bounce_irq", {31'h0, IRQ}, 32'h0); end
    end
    Addr = 2'd0; #1 chk("bounce_state", DOut, 32'h0);
    Addr = 2'd1; #1 chk("bounce_event", DOut, 32'h0);

    // Mask and enable.
    wr(2'd2, 4'b0011, 32'h101);
    KIn[5] = 1'b0;
    repeat (20) @(posedge Clk);
    #1 Addr = 2'd1;
    #1 chk("masked_event", DOut, 32'h20);
    chk("masked_irq", {31'h0, IRQ}, 32'h0);
    wr(2'd2, 4'b0001, 32'h20);
    #1 chk("unmasked_irq", {31'h0, IRQ}, 32'h1);
    wr(2'd2, 4'b0010, 32'h0);
    #1 chk("dis_ctrl", DOut, 32'h20);
    chk("dis_irq", {31'h0, IRQ}, 32'h0);
    KIn[6] = 1'b0;
    repeat (20) @(posedge Clk);
    #1 Addr = 2'd1;
    #1 chk("dis_event", DOut, 32'h20);
    Addr = 2'd0;
    #1 chk("dis_state", DOut, 32'h60);

    // Set/clear collision with DEBOUNCE=0 (tick every cycle).
    wr(2'd3, 4'b0111, 32'h0);
    wr(2'd2, 4'b0011, 32'h1FF);
    KIn[1] = 1'b0;
    repeat (4) @(posedge Clk);
    #1 Addr = 2'd0;
    #1 chk("coll_level_at_4", {31'h0, DOut[1]}, 32'h0);
    Addr = 2'd1; WE = 1'b1; BE = 4'b0001; DIn = 32'h22;
    @(posedge Clk); #1;
    WE = 1'b0; BE = 4'h0; Addr = 2'd0;
    #1 chk("coll_state_at_5", DOut, 32'h62);
    Addr = 2'd1;
    #1 chk("coll_event", DOut, 32'h02);
    chk("coll_irq", {31'h0, IRQ}, 32'h1);

    // DEBOUNCE rewrite mid-count restarts the prescaler.
    wr(2'd3, 4'b0111, 32'h1000);
    repeat (100) @(posedge Clk);
    #1 KIn[3] = 1'b0;
    repeat (5) @(posedge Clk);
    #1 Addr = 2'd3; WE = 1'b1; BE = 4'b0111; DIn = 32'hFF;
    @(posedge Clk); #1;
    WE = 1'b0; BE = 4'h0; Addr = 2'd0;
    repeat (764) @(posedge Clk);
    #1 chk("rewrite_level_764", {31'h0, DOut[3]}, 32'h0);
    @(posedge Clk);
    #1 chk("rewrite_level_765", {31'h0, DOut[3]}, 32'h1);
    Addr = 2'd1;
    #1 chk("rewrite_event", DOut, 32'h0A);
    Addr = 2'd3;
    #1 chk("rewrite_deb", DOut, 32'hFF);

    @(posedge Clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
